writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameters SHALL be taken from global_def.h: REG_WIDTH (register/data width), OPCODE_WIDTH (opcode width).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 I_CLOCK  in  1  stage clock; all state updates on negedge I_CLOCK.
REQ-004 I_RESET  in  1  synchronous active-high reset.
REQ-005 I_LOCK  in  1  pipeline running flag from memory stage; 0 = idle.
REQ-006 I_Opcode  in  OPCODE_WIDTH  opcode from memory stage.
REQ-007 I_ALUOut  in  REG_WIDTH  ALU result or link address from memory stage.
REQ-008 I_MemOut  in  REG_WIDTH  load data from memory stage.
REQ-009 I_DestRegIdx  in  4  destination register index.
REQ-010 I_FetchStall, I_DepStall  in  1 each  bubble markers from memory stage.
REQ-011 I_RdIdx0, I_RdIdx1  in  4 each  decode-stage read indices.
REQ-012 O_RdData0, O_RdData1  out  REG_WIDTH each  combinational register-file read data.
REQ-013 O_WBEnable  out  1  registered writeback strobe to decode scoreboard.
REQ-014 O_WBRegIdx  out  4  registered index written.
REQ-015 O_WBData  out  REG_WIDTH  registered value written.
REQ-016 O_RetireCount  out  16  valid instructions retired.
REQ-017 O_BubbleCount  out  16  bubbles received.

Function
REQ-018 Valid instruction: I_LOCK=1 and I_FetchStall=0 and I_DepStall=0 at the negedge.
REQ-019 Writing opcodes: OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_ANDI_D, OP_MOV, OP_MOVI_D, OP_JSR, OP_JSRR (data = I_ALUOut); OP_LDW (data = I_MemOut).
REQ-020 Non-writing opcodes: OP_STW, all OP_BR*, OP_JMP, any undefined encoding; no RF change.
REQ-021 Register file: 16 x REG_WIDTH; all 16 entries writable, R0 included.
REQ-022 For a valid writing instruction, RF[I_DestRegIdx] SHALL update at that negedge; latency 0 cycles from stage input.
REQ-023 Same edge: O_WBEnable<=1, O_WBRegIdx<=I_DestRegIdx, O_WBData<=write data; otherwise O_WBEnable<=0, with index/data holding their last values.
REQ-024 O_WBEnable SHALL be high for exactly one cycle per writing instruction; back-to-back writes keep it high on consecutive cycles.
REQ-025 Reads are combinational from RF; write-first bypass: if the current input is a valid writing instruction and I_RdIdxN equals I_DestRegIdx, O_RdDataN SHALL equal the in-flight write data.
REQ-026 Both read ports SHALL bypass independently; both may target the same index.
REQ-027 O_RetireCount +1 per valid instruction (any opcode); saturates at 0xFFFF.
REQ-028 O_BubbleCount +1 when I_LOCK=1 and (I_FetchStall or I_DepStall); saturates at 0xFFFF.
REQ-029 Both stall flags set in one cycle SHALL count as one bubble.
REQ-030 I_LOCK=0: no RF write, no counter change, O_WBEnable<=0.
REQ-031 Bubbles SHALL never write the RF, regardless of opcode or index.

Reset
REQ-032 I_RESET=1 at a negedge: all 16 RF entries <=0, O_WBEnable<=0, O_WBRegIdx<=0, O_WBData<=0, O_RetireCount<=0, O_BubbleCount<=0.
REQ-033 Reset SHALL take priority over any simultaneous valid instruction; that instruction is dropped and not counted.
REQ-034 During reset the read ports SHALL show the cleared RF contents (0) from the first negedge after assertion; bypass stays active.
REQ-035 Normal operation resumes on the first negedge with I_RESET=0.

Verification
REQ-036 Reset, then OP_ADD_D with I_DestRegIdx=3 and I_ALUOut=0x1234 -> RF[3]=0x1234; one-cycle O_WBEnable pulse with idx 3 and data 0x1234; RetireCount=1.
REQ-037 OP_LDW with idx 5, I_MemOut=0xBEEF, I_ALUOut=0x0010 -> RF[5]=0xBEEF; with I_RdIdx0=5 in the same cycle, O_RdData0=0xBEEF before the edge.
REQ-038 OP_STW, then OP_BRZ, then OP_JMP -> no RF change; O_WBEnable=0; RetireCount +3.
REQ-039 OP_MOVI_D with idx 2, data 0x00FF and I_DepStall=1 -> RF[2] unchanged; BubbleCount +1; RetireCount unchanged.
REQ-040 Preload both counters to 0xFFFE, then apply 3 valid instructions and 3 bubbles -> both counters stick at 0xFFFF.
REQ-041 Valid OP_ADDI_D with idx 7 and I_RESET=1 on the same edge -> RF[7]=0; all outputs 0; counters 0.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: 16-entry register file with write-first read bypass,
// a registered writeback strobe for the decode scoreboard, and retire/bubble counters.
module wb_read_port #(
    parameter int REG_WIDTH = 16
) (
    input  logic [3:0]                  rd_idx,
    input  logic [15:0][REG_WIDTH-1:0]  rf,
    input  logic                        byp_en,
    input  logic [3:0]                  byp_idx,
    input  logic [REG_WIDTH-1:0]        byp_data,
    output logic [REG_WIDTH-1:0]        rd_data
);
    assign rd_data = (byp_en && rd_idx == byp_idx) ? byp_data : rf[rd_idx];
endmodule

module writeback_stage #(
    parameter int REG_WIDTH    = 16,
    parameter int OPCODE_WIDTH = 8
) (
    input  logic                    I_CLOCK,
    input  logic                    I_RESET,
    input  logic                    I_LOCK,
    input  logic [OPCODE_WIDTH-1:0] I_Opcode,
    input  logic [REG_WIDTH-1:0]    I_ALUOut,
    input  logic [REG_WIDTH-1:0]    I_MemOut,
    input  logic [3:0]              I_DestRegIdx,
    input  logic                    I_FetchStall,
    input  logic                    I_DepStall,
    input  logic [3:0]              I_RdIdx0,
    input  logic [3:0]              I_RdIdx1,
    output logic [REG_WIDTH-1:0]    O_RdData0,
    output logic [REG_WIDTH-1:0]    O_RdData1,
    output logic                    O_WBEnable,
    output logic [3:0]              O_WBRegIdx,
    output logic [REG_WIDTH-1:0]    O_WBData,
    output logic [15:0]             O_RetireCount,
    output logic [15:0]             O_BubbleCount
);
    localparam int NUM_RD = 2;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D  = OPCODE_WIDTH'(8'h00);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI_D = OPCODE_WIDTH'(8'h01);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND_D  = OPCODE_WIDTH'(8'h02);
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI_D = OPCODE_WIDTH'(8'h03);
    localparam logic [OPCODE_WIDTH-1:0] OP_MOV    = OPCODE_WIDTH'(8'h04);
    localparam logic [OPCODE_WIDTH-1:0] OP_MOVI_D = OPCODE_WIDTH'(8'h05);
    localparam logic [OPCODE_WIDTH-1:0] OP_JSR    = OPCODE_WIDTH'(8'h06);
    localparam logic [OPCODE_WIDTH-1:0] OP_JSRR   = OPCODE_WIDTH'(8'h07);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW    = OPCODE_WIDTH'(8'h08);

    logic [15:0][REG_WIDTH-1:0]      rf;
    logic [NUM_RD-1:0][3:0]          rd_idx;
    logic [NUM_RD-1:0][REG_WIDTH-1:0] rd_data;
    logic                            valid, bubble, writes, wr_en;
    logic [REG_WIDTH-1:0]            wr_data;
    logic [15:0]                     retire_cnt, bubble_cnt;

    assign valid  = I_LOCK && !I_FetchStall && !I_DepStall;
    assign bubble = I_LOCK && (I_FetchStall || I_DepStall);

    // STW, branches, JMP and undefined encodings all fall to the non-writing default
    always_comb begin
        writes  = 1'b0;
        wr_data = I_ALUOut;
        case (I_Opcode)
            OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_ANDI_D,
            OP_MOV, OP_MOVI_D, OP_JSR, OP_JSRR: writes = 1'b1;
            OP_LDW: begin
                writes  = 1'b1;
                wr_data = I_MemOut;
            end
            default: writes = 1'b0;
        endcase
    end

    // Bypass ignores reset so decode sees the in-flight value even on a reset edge
    assign wr_en = valid && writes;

    assign rd_idx[0] = I_RdIdx0;
    assign rd_idx[1] = I_RdIdx1;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        wb_read_port #(.REG_WIDTH(REG_WIDTH)) u_rd (
            .rd_idx   (rd_idx[p]),
            .rf       (rf),
            .byp_en   (wr_en),
            .byp_idx  (I_DestRegIdx),
            .byp_data (wr_data),
            .rd_data  (rd_data[p])
        );
    end

    assign O_RdData0 = rd_data[0];
    assign O_RdData1 = rd_data[1];

    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            rf         <= '0;
            O_WBEnable <= 1'b0;
            O_WBRegIdx <= '0;
            O_WBData   <= '0;
            retire_cnt <= '0;
            bubble_cnt <= '0;
        end else begin
            O_WBEnable <= wr_en;
            if (wr_en) begin
                rf[I_DestRegIdx] <= wr_data;
                O_WBRegIdx       <= I_DestRegIdx;
                O_WBData         <= wr_data;
            end
            if (valid && retire_cnt != 16'hFFFF)
                retire_cnt <= retire_cnt + 16'd1;
            if (bubble && bubble_cnt != 16'hFFFF)
                bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

    assign O_RetireCount = retire_cnt;
    assign O_BubbleCount = bubble_cnt;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, randomized run against a
// behavioural register-file model, and hand sequences for saturation and reset priority.
module tb_writeback_stage;
    localparam logic [7:0] OP_ADD_D = 8'h00, OP_ADDI_D = 8'h01, OP_AND_D = 8'h02,
        OP_ANDI_D = 8'h03, OP_MOV = 8'h04, OP_MOVI_D = 8'h05, OP_JSR = 8'h06,
        OP_JSRR = 8'h07, OP_LDW = 8'h08, OP_STW = 8'h09, OP_BRN = 8'h0A,
        OP_BRZ = 8'h0B, OP_BRP = 8'h0C, OP_BRNZ = 8'h0D, OP_BRNP = 8'h0E,
        OP_BRZP = 8'h0F, OP_BRNZP = 8'h10, OP_JMP = 8'h11;

    logic I_CLOCK = 1'b0, I_RESET, I_LOCK, I_FetchStall, I_DepStall;
    logic [7:0]  I_Opcode;
    logic [15:0] I_ALUOut, I_MemOut;
    logic [3:0]  I_DestRegIdx, I_RdIdx0, I_RdIdx1;
    logic [15:0] O_RdData0, O_RdData1, O_WBData, O_RetireCount, O_BubbleCount;
    logic        O_WBEnable;
    logic [3:0]  O_WBRegIdx;

    writeback_stage #(.REG_WIDTH(16), .OPCODE_WIDTH(8)) dut (
        .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_Opcode(I_Opcode),
        .I_ALUOut(I_ALUOut), .I_MemOut(I_MemOut), .I_DestRegIdx(I_DestRegIdx),
        .I_FetchStall(I_FetchStall), .I_DepStall(I_DepStall),
        .I_RdIdx0(I_RdIdx0), .I_RdIdx1(I_RdIdx1),
        .O_RdData0(O_RdData0), .O_RdData1(O_RdData1), .O_WBEnable(O_WBEnable),
        .O_WBRegIdx(O_WBRegIdx), .O_WBData(O_WBData),
        .O_RetireCount(O_RetireCount), .O_BubbleCount(O_BubbleCount)
    );

    always #5 I_CLOCK = ~I_CLOCK;

    int n_checks = 0, n_errors = 0;

    typedef struct {
        logic rst, lock;
        logic [7:0] op;
        logic [15:0] alu, mem;
        logic [3:0] dest;
        logic fs, ds;
        logic [3:0] r0, r1;
        logic [15:0] e_r0, e_r1;
        logic e_en;
        logic [3:0] e_idx;
        logic [15:0] e_data, e_ret, e_bub;
    } vec_t;

    vec_t tbl [14];

    // behavioural reference state
    logic [15:0] rf_m [16];
    logic        en_m;
    logic [3:0]  idx_m;
    logic [15:0] data_m;
    int          ret_m, bub_m;

    logic [7:0] all_ops [18];
    logic [7:0] wr_ops  [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_writer(input logic [7:0] op);
        foreach (wr_ops[k]) if (wr_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_in(input logic rst, lock, input logic [7:0] op, input logic [15:0] alu, mem,
                          input logic [3:0] dest, input logic fs, ds, input logic [3:0] r0, r1);
        I_RESET = rst; I_LOCK = lock; I_Opcode = op; I_ALUOut = alu; I_MemOut = mem;
        I_DestRegIdx = dest; I_FetchStall = fs; I_DepStall = ds; I_RdIdx0 = r0; I_RdIdx1 = r1;
    endtask

    task automatic model_reset();
        foreach (rf_m[k]) rf_m[k] = '0;
        en_m = 1'b0; idx_m = '0; data_m = '0; ret_m = 0; bub_m = 0;
    endtask

    // one cycle checked against the model: reads before the edge, registers after it
    task automatic run_step(input string tag);
        bit wr, ok;
        logic [15:0] wd, e0, e1;
        ok = I_LOCK && !I_FetchStall && !I_DepStall;
        wr = ok && is_writer(I_Opcode);
        wd = (I_Opcode == OP_LDW) ? I_MemOut : I_ALUOut;
        @(posedge I_CLOCK); #1;
        e0 = (wr && I_RdIdx0 == I_DestRegIdx) ? wd : rf_m[I_RdIdx0];
        e1 = (wr && I_RdIdx1 == I_DestRegIdx) ? wd : rf_m[I_RdIdx1];
        check({tag, " rd0"}, 32'(O_RdData0), 32'(e0));
        check({tag, " rd1"}, 32'(O_RdData1), 32'(e1));
        if (I_RESET) model_reset();
        else begin
            en_m = wr;
            if (wr) begin rf_m[I_DestRegIdx] = wd; idx_m = I_DestRegIdx; data_m = wd; end
            if (ok) ret_m = (ret_m + 1 > 65535) ? 65535 : ret_m + 1;
            if (I_LOCK && (I_FetchStall || I_DepStall)) bub_m = (bub_m + 1 > 65535) ? 65535 : bub_m + 1;
        end
        @(negedge I_CLOCK); #1;
        check({tag, " wb_en"}, 32'(O_WBEnable), 32'(en_m));
        check({tag, " wb_idx"}, 32'(O_WBRegIdx), 32'(idx_m));
        check({tag, " wb_data"}, 32'(O_WBData), 32'(data_m));
        check({tag, " retire"}, 32'(O_RetireCount), 32'(ret_m));
        check({tag, " bubble"}, 32'(O_BubbleCount), 32'(bub_m));
    endtask

    initial begin
        all_ops = '{OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_ANDI_D, OP_MOV, OP_MOVI_D, OP_JSR, OP_JSRR,
                    OP_LDW, OP_STW, OP_BRN, OP_BRZ, OP_BRP, OP_BRNZ, OP_BRNP, OP_BRZP, OP_BRNZP, OP_JMP};
        wr_ops  = '{OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_ANDI_D, OP_MOV, OP_MOVI_D, OP_JSR, OP_JSRR, OP_LDW};

        //            rst  lock op         alu       mem       dest fs  ds  r0  r1   e_r0      e_r1      en  idx  data      ret  bub
        tbl[0]  = '{1'b0,1'b1,OP_ADD_D, 16'h1234,16'h0000,4'd3, 1'b0,1'b0,4'd3, 4'd0, 16'h1234,16'h0000,1'b1,4'd3, 16'h1234,16'd1,16'd0};
        tbl[1]  = '{1'b0,1'b1,OP_LDW,   16'h0010,16'hBEEF,4'd5, 1'b0,1'b0,4'd5, 4'd3, 16'hBEEF,16'h1234,1'b1,4'd5, 16'hBEEF,16'd2,16'd0};
        tbl[2]  = '{1'b0,1'b1,OP_STW,   16'h1111,16'h2222,4'd6, 1'b0,1'b0,4'd6, 4'd5, 16'h0000,16'hBEEF,1'b0,4'd5, 16'hBEEF,16'd3,16'd0};
        tbl[3]  = '{1'b0,1'b1,OP_BRZ,   16'h2222,16'h0000,4'd3, 1'b0,1'b0,4'd3, 4'd2, 16'h1234,16'h0000,1'b0,4'd5, 16'hBEEF,16'd4,16'd0};
        tbl[4]  = '{1'b0,1'b1,OP_JMP,   16'h3333,16'h0000,4'd5, 1'b0,1'b0,4'd5, 4'd5, 16'hBEEF,16'hBEEF,1'b0,4'd5, 16'hBEEF,16'd5,16'd0};
        tbl[5]  = '{1'b0,1'b1,OP_MOVI_D,16'h00FF,16'h0000,4'd2, 1'b0,1'b1,4'd2, 4'd2, 16'h0000,16'h0000,1'b0,4'd5, 16'hBEEF,16'd5,16'd1};
        tbl[6]  = '{1'b0,1'b0,OP_ADD_D, 16'h5555,16'h0000,4'd2, 1'b0,1'b0,4'd2, 4'd3, 16'h0000,16'h1234,1'b0,4'd5, 16'hBEEF,16'd5,16'd1};
        tbl[7]  = '{1'b0,1'b1,OP_AND_D, 16'hABCD,16'h0000,4'd0, 1'b1,1'b1,4'd0, 4'd0, 16'h0000,16'h0000,1'b0,4'd5, 16'hBEEF,16'd5,16'd2};
        tbl[8]  = '{1'b0,1'b1,OP_MOV,   16'h0A0A,16'h0000,4'd0, 1'b0,1'b0,4'd0, 4'd0, 16'h0A0A,16'h0A0A,1'b1,4'd0, 16'h0A0A,16'd6,16'd2};
        tbl[9]  = '{1'b0,1'b1,8'hFF,    16'h7777,16'h0000,4'd4, 1'b0,1'b0,4'd4, 4'd0, 16'h0000,16'h0A0A,1'b0,4'd0, 16'h0A0A,16'd7,16'd2};
        tbl[10] = '{1'b0,1'b1,OP_JSR,   16'h0040,16'h0000,4'd15,1'b0,1'b0,4'd15,4'd0, 16'h0040,16'h0A0A,1'b1,4'd15,16'h0040,16'd8,16'd2};
        tbl[11] = '{1'b0,1'b1,OP_JSRR,  16'h0080,16'h0000,4'd15,1'b0,1'b0,4'd15,4'd14,16'h0080,16'h0000,1'b1,4'd15,16'h0080,16'd9,16'd2};
        tbl[12] = '{1'b1,1'b1,OP_ADDI_D,16'h9999,16'h0000,4'd7, 1'b0,1'b0,4'd7, 4'd3, 16'h9999,16'h1234,1'b0,4'd0, 16'h0000,16'd0,16'd0};
        tbl[13] = '{1'b0,1'b0,OP_ADD_D, 16'h0000,16'h0000,4'd0, 1'b0,1'b0,4'd7, 4'd3, 16'h0000,16'h0000,1'b0,4'd0, 16'h0000,16'd0,16'd0};

        // reset state
        set_in(1'b1, 1'b0, OP_STW, '0, '0, '0, 1'b0, 1'b0, 4'd0, 4'd9);
        @(negedge I_CLOCK); #1;
        check("reset wb_en", 32'(O_WBEnable), 32'd0);
        check("reset wb_idx", 32'(O_WBRegIdx), 32'd0);
        check("reset wb_data", 32'(O_WBData), 32'd0);
        check("reset retire", 32'(O_RetireCount), 32'd0);
        check("reset bubble", 32'(O_BubbleCount), 32'd0);
        check("reset rd0", 32'(O_RdData0), 32'd0);
        check("reset rd1", 32'(O_RdData1), 32'd0);

        foreach (tbl[i]) begin
            set_in(tbl[i].rst, tbl[i].lock, tbl[i].op, tbl[i].alu, tbl[i].mem, tbl[i].dest,
                   tbl[i].fs, tbl[i].ds, tbl[i].r0, tbl[i].r1);
            @(posedge I_CLOCK); #1;
            check($sformatf("row%0d rd0", i), 32'(O_RdData0), 32'(tbl[i].e_r0));
            check($sformatf("row%0d rd1", i), 32'(O_RdData1), 32'(tbl[i].e_r1));
            @(negedge I_CLOCK); #1;
            check($sformatf("row%0d wb_en", i), 32'(O_WBEnable), 32'(tbl[i].e_en));
            check($sformatf("row%0d wb_idx", i), 32'(O_WBRegIdx), 32'(tbl[i].e_idx));
            check($sformatf("row%0d wb_data", i), 32'(O_WBData), 32'(tbl[i].e_data));
            check($sformatf("row%0d retire", i), 32'(O_RetireCount), 32'(tbl[i].e_ret));
            check($sformatf("row%0d bubble", i), 32'(O_BubbleCount), 32'(tbl[i].e_bub));
        end

        // randomized run against the model, starting from a reset cycle
        set_in(1'b1, 1'b0, OP_ADD_D, '0, '0, '0, 1'b0, 1'b0, '0, '0);
        run_step("rand_rst");
        for (int c = 0; c < 400; c++) begin
            logic [7:0] op;
            logic [3:0] dest, r0, r1;
            op   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : all_ops[$urandom_range(0, 17)];
            dest = 4'($urandom);
            r0   = ($urandom_range(0, 2) == 0) ? dest : 4'($urandom);
            r1   = ($urandom_range(0, 2) == 0) ? dest : 4'($urandom);
            set_in($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0, op, 16'($urandom),
                   16'($urandom), dest, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, r0, r1);
            run_step($sformatf("rand%0d", c));
        end

        // saturation: preload both counters just below the ceiling
        set_in(1'b1, 1'b0, OP_ADD_D, '0, '0, '0, 1'b0, 1'b0, '0, '0);
        run_step("sat_rst");
        dut.retire_cnt = 16'hFFFE;
        dut.bubble_cnt = 16'hFFFE;
        ret_m = 65534; bub_m = 65534;
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 1'b1, OP_ADD_D, 16'(k + 1), '0, 4'(k + 8), 1'b0, 1'b0, 4'(k + 8), 4'd0);
            run_step($sformatf("sat_valid%0d", k));
        end
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 1'b1, OP_MOV, 16'hDEAD, '0, 4'd1, k[0], 1'b1, 4'd1, 4'd8);
            run_step($sformatf("sat_bubble%0d", k));
        end
        check("sat retire final", 32'(O_RetireCount), 32'hFFFF);
        check("sat bubble final", 32'(O_BubbleCount), 32'hFFFF);

        // reset wins over a simultaneous valid write; R7 must read back cleared
        set_in(1'b0, 1'b1, OP_ADDI_D, 16'h4242, '0, 4'd7, 1'b0, 1'b0, 4'd7, 4'd7);
        run_step("pri_pre");
        set_in(1'b1, 1'b1, OP_ADDI_D, 16'h5A5A, '0, 4'd7, 1'b0, 1'b0, 4'd7, 4'd8);
        run_step("pri_rst");
        set_in(1'b0, 1'b0, OP_JMP, '0, '0, '0, 1'b0, 1'b0, 4'd7, 4'd8);
        @(posedge I_CLOCK); #1;
        check("pri rf7 cleared", 32'(O_RdData0), 32'd0);
        check("pri retire zero", 32'(O_RetireCount), 32'd0);
        check("pri wb_data zero", 32'(O_WBData), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
